// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// wait-counter width and the address decode helpers.
package mem_pkg;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    // Low address bits that must be zero for a word-aligned access.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = 32'h0000_0003;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // An access is rejected when it is misaligned or lies beyond the array.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int depth_log2);
        return ((addr & ALIGN_MASK) != '0) || ((addr >> (depth_log2 + 2)) != '0);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake between the control FSM (master) and the
// memory responder (slave).
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/mem_array.sv
// Single-port word storage with synchronous write and registered read.
module mem_array #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);
    logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] r_rdata;

    // Write or read the addressed word on the clock edge.
    // NOTE: storage has no reset so it maps onto RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one access at a time, inserts WAIT_CYCLES wait
// states, then returns a one-cycle registered response.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_req_ready;
    logic              r_busy;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              r_rsp_zero;

    logic                  w_idle;
    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_sel_write;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic                  w_err;
    logic [DEPTH_LOG2-1:0] w_index;
    logic                  w_we;
    logic                  w_re;
    logic [DATA_W-1:0]     w_arr_rdata;

    // In IDLE the access is taken straight from the bus (needed when there
    // are no wait states); afterwards the captured copy is used.
    assign w_idle       = (r_state == ST_IDLE);
    assign w_accept     = w_idle && bus.req_valid;
    assign w_enter_resp = (w_accept && NO_WAIT) || ((r_state == ST_WAIT) && (r_cnt == '0));
    assign w_sel_write  = w_idle ? bus.req_write : r_write;
    assign w_sel_addr   = w_idle ? bus.req_addr  : r_addr;
    assign w_sel_wdata  = w_idle ? bus.req_wdata : r_wdata;
    assign w_err        = addr_err(w_sel_addr, DEPTH_LOG2);
    assign w_index      = w_sel_addr[DEPTH_LOG2+1:2];

    // The array is touched only on the edge entering RESP, never under reset.
    assign w_we = reset && w_enter_resp &&  w_sel_write && !w_err;
    assign w_re = reset && w_enter_resp && !w_sel_write && !w_err;

    mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_index),
        .i_wdata (w_sel_wdata),
        .o_rdata (w_arr_rdata)
    );

    // Control FSM with request capture and registered handshake outputs.
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_zero  <= 1'b1;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_write     <= bus.req_write;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (NO_WAIT) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
            if (w_enter_resp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_zero  <= w_sel_write || w_err;
            end
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.busy      = r_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_zero ? '0 : w_arr_rdata;
endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed steps plus randomized accesses,
// checked against a word-array reference model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst2, rst0, use0;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] model_mem [256];
    bit          known     [256];

    mem_responder_if #(.DATA_W(32)) if2 ();
    mem_responder_if #(.DATA_W(32)) if0 ();

    mem_responder #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut2 (
        .clk   (clk),
        .reset (rst2),
        .bus   (if2.slave)
    );

    mem_responder #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (if0.slave)
    );

    assign if2.req_valid = req_valid && !use0;
    assign if0.req_valid = req_valid &&  use0;
    assign if2.req_write = req_write;
    assign if0.req_write = req_write;
    assign if2.req_addr  = req_addr;
    assign if0.req_addr  = req_addr;
    assign if2.req_wdata = req_wdata;
    assign if0.req_wdata = req_wdata;

    wire        rsp_valid = use0 ? if0.rsp_valid : if2.rsp_valid;
    wire [31:0] rsp_rdata = use0 ? if0.rsp_rdata : if2.rsp_rdata;
    wire        rsp_err   = use0 ? if0.rsp_err   : if2.rsp_err;
    wire        req_ready = use0 ? if0.req_ready : if2.req_ready;
    wire        busy      = use0 ? if0.busy      : if2.busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd1024);
    endfunction

    // Issue one access starting at a negedge; returns one negedge after the
    // response cycle. With hold=1, req_valid stays high and the address keeps
    // changing while the access is in flight.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input bit hold, output logic [31:0] rd, output logic err,
                          output int lat, output int acc);
        int guard;
        bit saw_ready;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait_bound", 32'(guard < 50), 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) begin
            req_valid = 1'b0;
            req_write = ~wr;
            req_addr  = $urandom;
            req_wdata = $urandom;
        end
        lat = 0;
        saw_ready = 1'b0;
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin
            if (req_ready) saw_ready = 1'b1;
            @(posedge clk);
            #1;
            if (hold) begin
                req_addr  = $urandom;
                req_write = $urandom;
                req_wdata = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        check("rsp_timeout", 32'(rsp_valid), 32'd1);
        check("ready_low_in_wait", 32'(saw_ready), 32'd0);
        check("ready_low_in_resp", 32'(req_ready), 32'd0);
        check("busy_in_resp", 32'(busy), 32'd1);
        rd  = rsp_rdata;
        err = rsp_err;
        @(negedge clk);
        check("rsp_valid_one_cycle", 32'(rsp_valid), 32'd0);
        check("rdata_held", rsp_rdata, rd);
        check("err_held", 32'(rsp_err), 32'(err));
        check("ready_after_resp", 32'(req_ready), 32'd1);
        check("idle_after_resp", 32'(busy), 32'd0);
    endtask

    // Run one access and compare it against the reference model.
    task automatic model_access(input string tag, input bit wr, input logic [31:0] addr,
                                input logic [31:0] wd, input bit hold, input int wait_cycles,
                                output int acc);
        logic [31:0] rd;
        logic        err;
        int          lat;
        bit          e;
        int          idx;
        access(wr, addr, wd, hold, rd, err, lat, acc);
        e   = exp_err(addr);
        idx = int'(addr / 4) % 256;
        check({tag, "_err"}, 32'(err), 32'(e));
        check({tag, "_lat"}, lat, wait_cycles);
        if (wr || e) begin
            check({tag, "_rdata_zero"}, rd, 32'd0);
        end else if (known[idx]) begin
            check({tag, "_rdata"}, rd, model_mem[idx]);
        end
        if (wr && !e) begin
            model_mem[idx] = wd;
            known[idx]     = 1'b1;
        end
    endtask

    initial begin
        int a1, a2, a3, hits;
        logic [31:0] addr;
        rst2 = 1'b0; rst0 = 1'b0; use0 = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst2 = 1'b1; rst0 = 1'b1;

        // Reset state while idle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_ready", 32'(req_ready), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rdata", rsp_rdata, 32'd0);
        end

        // Store then load with two wait states; back-to-back turnaround.
        model_access("st0", 1'b1, 32'h000, 32'h1122_3344, 1'b0, 2, a1);
        model_access("st10", 1'b1, 32'h010, 32'hDEAD_BEEF, 1'b0, 2, a1);
        model_access("ld10", 1'b0, 32'h010, 32'h0, 1'b0, 2, a2);
        check("turnaround_w2", a2 - a1, 4);

        // Error accesses, then word 0 must be untouched.
        model_access("ld_misal", 1'b0, 32'h012, 32'h0, 1'b0, 2, a1);
        model_access("st_oor", 1'b1, 32'h400, 32'h5555_AAAA, 1'b0, 2, a1);
        model_access("ld0", 1'b0, 32'h000, 32'h0, 1'b0, 2, a1);

        // Request held high with a changing address during the access.
        model_access("st20", 1'b1, 32'h020, 32'h0BAD_C0DE, 1'b0, 2, a1);
        model_access("ld10_hold", 1'b0, 32'h010, 32'h0, 1'b1, 2, a1);
        model_access("ld20_next", 1'b0, 32'h020, 32'h0, 1'b0, 2, a2);
        check("accept_after_resp", a2 - a1, 4);

        // Reset during WAIT of a store: no response, store dropped.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h020; req_wdata = 32'hFFFF_0000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_wait", 32'(busy), 32'd1);
        rst2 = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst2 = 1'b1;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) hits++;
        end
        check("abort_no_response", hits, 0);
        model_access("ld20_after_abort", 1'b0, 32'h020, 32'h0, 1'b0, 2, a1);

        // Randomized accesses against the model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom % 8)
                6:       addr = {22'd0, 8'($urandom), 2'b00} | 32'(1 + $urandom % 3);
                7:       addr = ($urandom & ~32'h3FF) | 32'h400;
                default: addr = {22'd0, 8'($urandom), 2'b00};
            endcase
            model_access("rand", 1'($urandom), addr, $urandom, 1'($urandom), 2, a3);
        end

        // Zero wait states: top word, two-cycle turnaround.
        @(negedge clk);
        use0 = 1'b1;
        @(negedge clk);
        model_access("w0_st3fc", 1'b1, 32'h3FC, 32'hA5A5_5A5A, 1'b0, 0, a1);
        model_access("w0_ld3fc", 1'b0, 32'h3FC, 32'h0, 1'b0, 0, a2);
        check("turnaround_w0", a2 - a1, 2);
        model_access("w0_oor", 1'b0, 32'h1000, 32'h0, 1'b0, 0, a1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
